seg7_scan_drv: RTL and testbench
================================

Name: seg7_scan_drv

Overview:
- Display back-end for the digital clock. Consumes the six 4-bit BCD digits produced by the clock counter chain (HH:MM:SS) and drives a 6-digit multiplexed common-cathode 7-segment display.
- Time-multiplexes one digit at a time and snapshots all digits once per frame, so a display frame never mixes old and new digits.
- Supports per-digit blinking (time-set mode), per-digit decimal points, and leading-zero blanking of the hour-tens digit.

Parameters:
SCAN_DIV, 1000, in_clk cycles each digit is held; minimum 2
BLINK_FRAMES, 100, full scan frames per blink half-period; minimum 1
NUM_DIGITS, 6, digit count; fixed at 6 for this design

Ports:
in_clk  input  1  system clock; all state is on its rising edge
rst  input  1  asynchronous active-low reset
digits  input  24  BCD digits; digit i = digits[4i+3:4i]; i=0 sec ones ... i=5 hour tens
blink_mask  input  6  bit i=1: digit i blinks
dp_mask  input  6  bit i=1: decimal point lit on digit i
blank_lz  input  1  1: blank digit 5 when its snapshot value is 0
seg  output  7  segments, active-high, bit0=a ... bit6=g
dp  output  1  decimal point, active-high
com  output  6  digit enables, active-low, one-hot-low when active

Behaviour:
- Reset is asynchronous and active-low: rst=0 immediately forces all registers to their reset values.
- Reset values: pre=0, idx=0, snap=0, frame_cnt=0, phase=0, seg=0, dp=0, com=6'b111111.
- Prescaler pre: counts 0..SCAN_DIV-1. At the edge where pre==SCAN_DIV-1, pre wraps to 0 and idx advances.
- idx wraps NUM_DIGITS-1 -> 0. frame_end = (pre==SCAN_DIV-1) && (idx==NUM_DIGITS-1).
- Snapshot: on the frame_end edge, snap <= digits. No other load; inputs between frame ends are ignored.
- Output registers: updated every edge from the current (pre-edge) idx, snap, phase and masks. One-cycle latency; each digit is visible for exactly SCAN_DIV consecutive cycles.
  - com: bit idx low, all other bits high.
  - seg: decode of snap digit idx:
    0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
    10..15 (invalid BCD) = 40, a dash on segment g only
  - dp: dp_mask[idx].
- Blanking forces seg=0 and dp=0 while com stays active. A digit is blanked if either holds:
  - phase==1 and blink_mask[idx]==1
  - idx==5, blank_lz==1 and snap digit 5==0
- Blink: on each frame_end edge, frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and phase toggles.
- blink_mask, dp_mask and blank_lz are sampled live, not snapshotted.
- Simultaneous events: on a frame_end edge, the output shows idx=5 from the old snap and old phase; the next edge shows idx=0 from the new snap and new phase.
- Reset mid-scan: outputs go dark immediately (com=111111). The first edge after release shows digit 0 from snap=0.
- Counter widths: pre is ceil(log2(SCAN_DIV)) bits, frame_cnt is ceil(log2(BLINK_FRAMES))+1 bits, idx is 3 bits. No counter may exceed its terminal value.

Decomposition:
- Shared package: segment pattern constants SEG_0..SEG_9 and SEG_DASH, plus COM_OFF=6'b111111.
- One sub-module: bcd_to_seg7 (4-bit in, 7-bit out, combinational), instantiated once on the muxed snap digit.

Test Plan:
- SCAN_DIV=4, digits=0x123456, reset then release -> edges 1-4: com=111110, seg=SEG_0. Edge 5: com=111101, seg=SEG_0. Edge 9: com=111011, seg=SEG_0 (snap still 0). After frame_end (edge 24): edge 25 com=111110, seg=7D (digit 0 = 6), then 6D, 66, 4F, 5B, 06 each for 4 cycles.
- Change digits mid-frame -> displayed values unchanged until the first idx=0 slot after the next frame_end; no mixed frame.
- digits=0x09_59_59, blank_lz=1 -> digit 5 slot: com=011111, seg=0. With blank_lz=0 the same slot shows seg=3F.
- BLINK_FRAMES=2, blink_mask=000011 -> digits 0-1 show normally for 2 frames, then seg=0/dp=0 for 2 frames with com still cycling; digits 2-5 are never blanked.
- Digit value 0xC on digit 2, dp_mask=000100 -> digit 2 slot: seg=40, dp=1; all other slots dp=0.
- rst pulsed low mid-digit -> com=111111, seg=0, dp=0 asynchronously. After release, the scan restarts at digit 0 with a 4-cycle hold.

Source files
------------

// File: rtl/seg7_scan_drv_pkg.sv
// Shared constants for the 6-digit multiplexed 7-segment display driver.
// Segment patterns are active-high with bit0=a ... bit6=g.
package seg7_scan_drv_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

   localparam logic [5:0] COM_OFF  = 6'b111111;

   typedef enum logic {
      PHASE_ON  = 1'b0,
      PHASE_OFF = 1'b1
   } blink_phase_t;

endpackage

// File: rtl/seg7_scan_drv_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; any non-BCD code shows a dash.
module bcd_to_seg7
   import seg7_scan_drv_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_drv.sv
// Multiplexed 6-digit common-cathode display scanner with per-frame digit
// snapshot, per-digit blink and decimal point, and hour-tens zero blanking.
module seg7_scan_drv
   import seg7_scan_drv_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 100
) (
   input  logic        in_clk,
   input  logic        rst,
   input  logic [23:0] digits,
   input  logic [5:0]  blink_mask,
   input  logic [5:0]  dp_mask,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [5:0]  com
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int FC_W  = $clog2(BLINK_FRAMES) + 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
   localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

   logic [PRE_W-1:0] pre;
   logic [2:0]       idx;
   logic [23:0]      snap;
   logic [FC_W-1:0]  frame_cnt;
   blink_phase_t     phase;

   logic             digit_end;
   logic             frame_end;
   logic [3:0]       cur_digit;
   logic             cur_blink;
   logic             cur_dp;
   logic [5:0]       cur_com;
   logic [6:0]       dec_seg;
   logic             blank;

   assign digit_end = (pre == PRE_LAST);
   assign frame_end = digit_end && (idx == IDX_LAST);

   // Select the active digit's snapshot value and live mask bits.
   always_comb begin
      cur_digit = 4'd0;
      cur_blink = 1'b0;
      cur_dp    = 1'b0;
      cur_com   = COM_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == 3'(i)) begin
            cur_digit  = snap[4*i +: 4];
            cur_blink  = blink_mask[i];
            cur_dp     = dp_mask[i];
            cur_com[i] = 1'b0;
         end
      end
   end

   assign blank = ((phase == PHASE_OFF) && cur_blink) ||
                  ((idx == IDX_LAST) && blank_lz && (snap[23:20] == 4'd0));

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (dec_seg)
   );

   // Digits are only re-sampled at frame end so one frame never mixes two times.
   always_ff @(posedge in_clk or negedge rst) begin
      if (!rst) begin
         pre       <= '0;
         idx       <= '0;
         snap      <= '0;
         frame_cnt <= '0;
         phase     <= PHASE_ON;
         seg       <= '0;
         dp        <= 1'b0;
         com       <= COM_OFF;
      end else begin
         if (digit_end) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
         end else begin
            pre <= pre + PRE_W'(1);
         end

         if (frame_end) begin
            snap <= digits;
            if (frame_cnt == FC_LAST) begin
               frame_cnt <= '0;
               phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
               frame_cnt <= frame_cnt + FC_W'(1);
            end
         end

         com <= cur_com;
         seg <= blank ? 7'd0 : dec_seg;
         dp  <= cur_dp & ~blank;
      end
   end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Scoreboard bench for seg7_scan_drv: stimulus queues hand-computed per-edge
// outputs, a monitor pops and compares one entry per clock.
module tb_seg7_scan_drv;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [5:0] com;
   } out_t;

   logic        in_clk;
   logic        rst;
   logic [23:0] digits;
   logic [5:0]  blink_mask;
   logic [5:0]  dp_mask;
   logic        blank_lz;
   logic [6:0]  seg;
   logic        dp;
   logic [5:0]  com;

   out_t  expq[$];
   string tagq[$];
   int    checks = 0;
   int    fails  = 0;

   seg7_scan_drv #(
      .SCAN_DIV     (4),
      .BLINK_FRAMES (2)
   ) dut (
      .in_clk     (in_clk),
      .rst        (rst),
      .digits     (digits),
      .blink_mask (blink_mask),
      .dp_mask    (dp_mask),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .dp         (dp),
      .com        (com)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   task automatic checkOutput(input string name, input logic [6:0] es,
                              input logic ed, input logic [5:0] ec);
      checks++;
      if ({seg, dp, com} !== {es, ed, ec}) begin
         fails++;
         $display("[TB] FAIL %s: got seg=%h dp=%b com=%b, expected seg=%h dp=%b com=%b",
                  name, seg, dp, com, es, ed, ec);
      end
   endtask

   task automatic applyStimulus(input logic [23:0] dg, input logic [5:0] bm,
                                input logic [5:0] dm, input logic blz);
      digits     = dg;
      blink_mask = bm;
      dp_mask    = dm;
      blank_lz   = blz;
   endtask

   task automatic pushSlot(input int idx, input logic [6:0] s, input logic d,
                           input int n, input string name);
      logic [5:0] c;
      c      = 6'b111111;
      c[idx] = 1'b0;
      for (int k = 0; k < n; k++) begin
         expq.push_back({s, d, c});
         tagq.push_back(name);
      end
   endtask

   // segs packs expected patterns as {d5, d4, d3, d2, d1, d0}.
   task automatic pushFrame(input logic [41:0] segs, input logic [5:0] dps,
                            input string name);
      for (int i = 0; i < 6; i++)
         pushSlot(i, segs[7*i +: 7], dps[i], 4, $sformatf("%s_d%0d", name, i));
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(negedge in_clk);
      #1;
   endtask

   initial begin
      out_t  e;
      string t;
      forever begin
         @(negedge in_clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            checkOutput(t, e.seg, e.dp, e.com);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(24'h123456, 6'b000000, 6'b000000, 1'b0);
      #2 rst = 1'b0;
      #1 checkOutput("reset_async", 7'h00, 1'b0, 6'b111111);
      waitEdges(1);
      checkOutput("reset_held", 7'h00, 1'b0, 6'b111111);

      // First frame still shows the all-zero reset snapshot.
      rst = 1'b1;
      pushFrame({6{7'h3F}}, 6'b000000, "f0_zero_snap");
      waitEdges(24);

      // Digits change mid-frame; this frame must keep showing 123456.
      pushFrame({7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b000000, "f1_123456");
      waitEdges(10);
      applyStimulus(24'h095959, 6'b000000, 6'b000000, 1'b0);
      waitEdges(14);

      pushFrame({7'h3F, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 6'b000000, "f2_lz_off");
      waitEdges(24);

      applyStimulus(24'h095959, 6'b000000, 6'b000000, 1'b1);
      pushFrame({7'h00, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 6'b000000, "f3_lz_on");
      waitEdges(24);

      applyStimulus(24'h000C00, 6'b000011, 6'b000100, 1'b0);
      pushFrame({7'h3F, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 6'b000100, "f4_blink_on");
      waitEdges(24);

      pushFrame({7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h3F, 7'h3F}, 6'b000100, "f5_dash");
      waitEdges(24);

      applyStimulus(24'h000C00, 6'b000011, 6'b000111, 1'b0);
      pushFrame({7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h00, 7'h00}, 6'b000100, "f6_blink_off");
      waitEdges(24);
      pushFrame({7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h00, 7'h00}, 6'b000100, "f7_blink_off");
      waitEdges(24);

      pushSlot(0, 7'h3F, 1'b1, 4, "f8_blink_back_d0");
      pushSlot(1, 7'h3F, 1'b1, 2, "f8_blink_back_d1");
      waitEdges(6);

      // Reset mid-digit: dark immediately, then scan restarts at digit 0.
      rst = 1'b0;
      #1 checkOutput("midscan_reset_async", 7'h00, 1'b0, 6'b111111);
      expq.push_back({7'h00, 1'b0, 6'b111111});
      tagq.push_back("midscan_reset_held");
      waitEdges(1);
      rst = 1'b1;
      pushFrame({6{7'h3F}}, 6'b000111, "f9_after_reset");
      waitEdges(24);

      waitEdges(2);
      checks++;
      if (expq.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0",
                  expq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
